// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares the single-port 8-bit video RAM between the video fetch,
//            a small in-order CPU write buffer, and the tape/snapshot loader.
//            One RAM access per clk_sys cycle; video always wins, the loader
//            is served when the CPU buffer is empty or after it has waited
//            STARVE_LIMIT cycles, otherwise the buffer drains.
// Ports    : clk_sys/nRESET          clock, async active-low reset
//            vid_rd/vid_addr         video fetch request (always granted)
//            vid_dout/vid_valid      video read data, one cycle after vid_rd
//            cpu_we/cpu_addr/cpu_din CPU write strobe into the buffer
//            cpu_full/cpu_ovf        buffer full / sticky dropped-write flag
//            ldr_req/ldr_we/ldr_addr/ldr_din  loader level request
//            ldr_ack/ldr_dout        loader completion pulse and read data
//            ram_addr/ram_din/ram_we/ram_dout VRAM macro interface
//            (registered read, 1-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int AW           = 15,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk_sys,
  input  logic          nRESET,
  input  logic          vid_rd,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_dout,
  output logic          vid_valid,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_full,
  output logic          cpu_ovf,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [7:0]    ldr_din,
  output logic          ldr_ack,
  output logic [7:0]    ldr_dout,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_LDR  = 2'd2,
    GNT_FIFO = 2'd3
  } grant_t;

  grant_t        grant_d, grant_q;
  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          full_d, full_q;
  logic          ovf_d, ovf_q;
  logic          pend_d, pend_q;
  logic [SW-1:0] starve_d, starve_q;

  logic [AW-1:0] mem_addr_q [FIFO_DEPTH];
  logic [7:0]    mem_data_q [FIFO_DEPTH];

  logic fifo_empty;
  logic ldr_eligible;
  logic push;
  logic pop;

  assign fifo_empty = (count_q == '0);

  // --------------------------------------------------------------------------
  // Grant selection. Forced to IDLE while nRESET is low so the RAM bus stays
  // quiet (no stray writes) for the whole reset period, not just after the
  // first clock edge.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_d      = GNT_IDLE;
    ldr_eligible = ldr_req & ~pend_q & (fifo_empty | (starve_q == LIMIT_C));
    if (!nRESET) begin
      grant_d = GNT_IDLE;
    end else if (vid_rd) begin
      grant_d = GNT_VID;
    end else if (ldr_eligible) begin
      grant_d = GNT_LDR;
    end else if (!fifo_empty) begin
      grant_d = GNT_FIFO;
    end
  end

  // RAM bus: only the winner of this cycle drives it; everything else is 0.
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    unique case (grant_d)
      GNT_VID: begin
        ram_addr = vid_addr;
      end
      GNT_LDR: begin
        ram_addr = ldr_addr;
        ram_din  = ldr_din;
        ram_we   = ldr_we;
      end
      GNT_FIFO: begin
        ram_addr = mem_addr_q[rd_ptr_q];
        ram_din  = mem_data_q[rd_ptr_q];
        ram_we   = 1'b1;
      end
      default: begin
        ram_addr = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // CPU write buffer. A push into a full buffer is still accepted when the
  // head retires in the same cycle. No bypass: an entry pushed into an empty
  // buffer becomes visible to the grant logic on the following cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    pop      = (grant_d == GNT_FIFO);
    push     = cpu_we & (~full_q | pop);
    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    full_d   = (count_d == DEPTH_C);
    ovf_d    = ovf_q | (cpu_we & ~push);
  end

  // --------------------------------------------------------------------------
  // Loader bookkeeping. pend covers the grant-to-ack window so the same held
  // request is not granted twice. The starve counter only runs while the
  // loader is actually eligible to wait (requesting, nothing outstanding).
  // --------------------------------------------------------------------------
  always_comb begin
    pend_d   = (grant_d == GNT_LDR) | (pend_q & ~ldr_ack);
    starve_d = starve_q;
    if ((grant_d == GNT_LDR) || !ldr_req) begin
      starve_d = '0;
    end else if (!pend_q && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      grant_q  <= GNT_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
      starve_q <= '0;
    end else begin
      grant_q  <= grant_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      starve_q <= starve_d;
    end
  end

  // Buffer storage needs no reset: occupancy is tracked by count/pointers.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= cpu_addr;
      mem_data_q[wr_ptr_q] <= cpu_din;
    end
  end

  // The RAM returns read data one cycle after the grant, so the registered
  // grant qualifies ram_dout. Data outputs are held at 0 when not valid.
  assign vid_valid = (grant_q == GNT_VID);
  assign ldr_ack   = (grant_q == GNT_LDR);
  assign vid_dout  = vid_valid ? ram_dout : 8'h00;
  assign ldr_dout  = ldr_ack ? ram_dout : 8'h00;
  assign cpu_full  = full_q;
  assign cpu_ovf   = ovf_q;

endmodule
`default_nettype wire
